// File: rtl/dbg_regfile_port_if.sv
// Host-side request/response bundle for the debug register-file port.
// The host drives requests; the port answers with one response per request.
interface dbg_regfile_port_if #(
    parameter int XLEN = 32
);
    logic            dbg_req_valid;
    logic            dbg_req_ready;
    logic            dbg_req_we;
    logic            dbg_req_pc;
    logic [4:0]      dbg_req_addr;
    logic [XLEN-1:0] dbg_req_wdata;
    logic            dbg_hold;
    logic            dbg_rsp_valid;
    logic            dbg_rsp_ready;
    logic [XLEN-1:0] dbg_rsp_rdata;
    logic            dbg_rsp_err;

    modport master (
        output dbg_req_valid,
        input  dbg_req_ready,
        output dbg_req_we,
        output dbg_req_pc,
        output dbg_req_addr,
        output dbg_req_wdata,
        output dbg_hold,
        input  dbg_rsp_valid,
        output dbg_rsp_ready,
        input  dbg_rsp_rdata,
        input  dbg_rsp_err
    );

    modport slave (
        input  dbg_req_valid,
        output dbg_req_ready,
        input  dbg_req_we,
        input  dbg_req_pc,
        input  dbg_req_addr,
        input  dbg_req_wdata,
        input  dbg_hold,
        output dbg_rsp_valid,
        input  dbg_rsp_ready,
        output dbg_rsp_rdata,
        output dbg_rsp_err
    );
endinterface

// File: rtl/dbg_regfile_port.sv
// Debug access port: halts the core, does one GPR/PC access, responds,
// then releases the core unless the host asked to keep it halted.
module dbg_regfile_port #(
    parameter int XLEN         = 32,
    parameter int HALT_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    dbg_regfile_port_if.slave   bus,
    output logic                cpu_halt_req,
    input  logic                cpu_halted,
    input  logic [XLEN-1:0]     cpu_pc,
    output logic                rf_dbg_en,
    output logic                rf_dbg_we,
    output logic [4:0]          rf_dbg_addr,
    output logic [XLEN-1:0]     rf_dbg_wdata,
    input  logic [XLEN-1:0]     rf_dbg_rdata
);
    localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        ACCESS,
        RESP
    } state_t;

    state_t          state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic            hold_q, hold_d;
    logic            req_we, req_we_d;
    logic            req_pc, req_pc_d;
    logic [4:0]      req_addr, req_addr_d;
    logic [XLEN-1:0] req_wdata, req_wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic req_ready;
    logic rsp_valid;

    // Exactly one of these is true for any latched request.
    logic pc_wr, pc_rd, gpr_wr0, gpr_wr, gpr_rd;
    assign pc_wr   = req_pc & req_we;
    assign pc_rd   = req_pc & ~req_we;
    assign gpr_wr0 = ~req_pc & req_we & (req_addr == 5'd0);
    assign gpr_wr  = ~req_pc & req_we & (req_addr != 5'd0);
    assign gpr_rd  = ~req_pc & ~req_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_q    <= 1'b0;
            req_we    <= 1'b0;
            req_pc    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hold_q    <= hold_d;
            req_we    <= req_we_d;
            req_pc    <= req_pc_d;
            req_addr  <= req_addr_d;
            req_wdata <= req_wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        hold_d       = hold_q;
        req_we_d     = req_we;
        req_pc_d     = req_pc;
        req_addr_d   = req_addr;
        req_wdata_d  = req_wdata;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        cpu_halt_req = 1'b1;
        rf_dbg_en    = 1'b0;
        rf_dbg_we    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready    = 1'b1;
                cpu_halt_req = hold_q;
                if (bus.dbg_req_valid) begin
                    req_we_d    = bus.dbg_req_we;
                    req_pc_d    = bus.dbg_req_pc;
                    req_addr_d  = bus.dbg_req_addr;
                    req_wdata_d = bus.dbg_req_wdata;
                    hold_d      = bus.dbg_hold;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = HALT;
                end
            end
            HALT: begin
                if (cpu_halted) begin
                    state_d = ACCESS;
                end else if (cnt == CNT_LAST) begin
                    // Core never stopped: give up without touching the RF.
                    err_d   = 1'b1;
                    rdata_d = '0;
                    hold_d  = 1'b0;
                    state_d = RESP;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            ACCESS: begin
                unique case (1'b1)
                    pc_wr, gpr_wr0: err_d = 1'b1;
                    pc_rd: rdata_d = cpu_pc;
                    gpr_wr: begin
                        rf_dbg_en = 1'b1;
                        rf_dbg_we = 1'b1;
                    end
                    gpr_rd: begin
                        rf_dbg_en = 1'b1;
                        rdata_d   = (req_addr == 5'd0) ? '0 : rf_dbg_rdata;
                    end
                    default: ;
                endcase
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.dbg_rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign rf_dbg_addr       = req_addr;
    assign rf_dbg_wdata      = req_wdata;
    assign bus.dbg_req_ready = req_ready;
    assign bus.dbg_rsp_valid = rsp_valid;
    assign bus.dbg_rsp_rdata = rdata_q;
    assign bus.dbg_rsp_err   = err_q;
endmodule

// File: tb/tb_dbg_regfile_port.sv
// Directed bench for dbg_regfile_port: vector table plus hand sequences
// for response stall, hold, and reset during a halt wait.
module tb_dbg_regfile_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_halt_req;
    logic        cpu_halted;
    logic [31:0] cpu_pc = 32'h0000_0040;
    logic        rf_dbg_en;
    logic        rf_dbg_we;
    logic [4:0]  rf_dbg_addr;
    logic [31:0] rf_dbg_wdata;
    logic [31:0] rf_dbg_rdata;

    logic        halted_force = 1'b1;
    logic        core_mode = 1'b0;
    logic        core_q = 1'b0;
    logic        rf_bad = 1'b0;
    logic        rf_clr = 1'b1;
    logic [31:0] rf [32];
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          total = 0;
    int          bad = 0;

    dbg_regfile_port_if #(.XLEN(32)) bus ();

    dbg_regfile_port #(
        .XLEN(32),
        .HALT_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cpu_halt_req(cpu_halt_req),
        .cpu_halted(cpu_halted),
        .cpu_pc(cpu_pc),
        .rf_dbg_en(rf_dbg_en),
        .rf_dbg_we(rf_dbg_we),
        .rf_dbg_addr(rf_dbg_addr),
        .rf_dbg_wdata(rf_dbg_wdata),
        .rf_dbg_rdata(rf_dbg_rdata)
    );

    always #5 clk = ~clk;

    // Core model: either forced, or halts one cycle after being asked.
    always @(posedge clk) core_q <= cpu_halt_req;
    assign cpu_halted = core_mode ? core_q : halted_force;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (rf_dbg_en && rf_dbg_we) begin
            rf[rf_dbg_addr] <= rf_dbg_wdata;
        end
        if (rf_dbg_en) en_cnt <= en_cnt + 1;
        if (rf_dbg_en && rf_dbg_we) wr_cnt <= wr_cnt + 1;
    end

    assign rf_dbg_rdata = rf_bad ? 32'hDEAD_BEEF : rf[rf_dbg_addr];

    typedef struct {
        logic        we;
        logic        pc;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        hold;
        logic        halted;
        logic        bad_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_en;
        int          exp_wr;
        logic        exp_hreq;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // lat = cycles from the accept cycle to the first cycle with rsp_valid.
    task automatic run_txn(input logic we, input logic pc,
                           input logic [4:0] addr, input logic [31:0] wdata,
                           input logic hold, input int stall,
                           input logic [31:0] exp_rd,
                           output logic [31:0] rdata, output logic err,
                           output int lat);
        int n;
        @(negedge clk);
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = we;
        bus.dbg_req_pc    = pc;
        bus.dbg_req_addr  = addr;
        bus.dbg_req_wdata = wdata;
        bus.dbg_hold      = hold;
        bus.dbg_rsp_ready = 1'b0;
        n = 0;
        while (!bus.dbg_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("req_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.dbg_req_valid = 1'b0;
        lat = 1;
        while (!bus.dbg_rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat == 40) chk("rsp_wait", 32'd0, 32'd1);
        rdata = bus.dbg_rsp_rdata;
        err   = bus.dbg_rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.dbg_rsp_valid}, 32'd1);
            chk("stall_rdata", bus.dbg_rsp_rdata, exp_rd);
            chk("stall_ready", {31'd0, bus.dbg_req_ready}, 32'd0);
            chk("stall_hreq", {31'd0, cpu_halt_req}, 32'd1);
        end
        @(negedge clk);
        bus.dbg_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.dbg_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          e0;
        int          w0;

        vecs[0] = '{1'b1, 1'b0, 5'd6, 32'h1234_5678, 1'b0, 1'b1, 1'b0,
                    32'h0, 1'b0, 3, 1, 1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b0,
                    32'h1234_5678, 1'b0, 3, 1, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1,
                    32'h0, 1'b0, 3, 1, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                    32'h0, 1'b1, 3, 0, 0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0,
                    32'h0000_0040, 1'b0, 3, 0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 5'd3, 32'h1111_2222, 1'b0, 1'b1, 1'b0,
                    32'h0, 1'b1, 3, 0, 0, 1'b0};
        // Timeout: 8 HALT cycles after the accept cycle; hold is dropped.
        vecs[6] = '{1'b1, 1'b0, 5'd7, 32'h0000_AAAA, 1'b1, 1'b0, 1'b0,
                    32'h0, 1'b1, 9, 0, 0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1, 1'b0,
                    32'h0, 1'b0, 3, 1, 0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 5'd31, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0,
                    32'h0, 1'b0, 3, 1, 1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 5'd31, 32'h0, 1'b0, 1'b1, 1'b0,
                    32'hCAFE_F00D, 1'b0, 3, 1, 0, 1'b0};

        bus.dbg_req_valid = 1'b0;
        bus.dbg_req_we    = 1'b0;
        bus.dbg_req_pc    = 1'b0;
        bus.dbg_req_addr  = 5'd0;
        bus.dbg_req_wdata = 32'h0;
        bus.dbg_hold      = 1'b0;
        bus.dbg_rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.dbg_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.dbg_rsp_valid}, 32'd0);
        chk("rst_rdata", bus.dbg_rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.dbg_rsp_err}, 32'd0);
        chk("rst_halt_req", {31'd0, cpu_halt_req}, 32'd0);
        chk("rst_rf_en", {31'd0, rf_dbg_en}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_dbg_we}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        rf_clr = 1'b0;

        for (int v = 0; v < 10; v++) begin
            halted_force = vecs[v].halted;
            rf_bad       = vecs[v].bad_rd;
            e0 = en_cnt;
            w0 = wr_cnt;
            run_txn(vecs[v].we, vecs[v].pc, vecs[v].addr, vecs[v].wdata,
                    vecs[v].hold, 0, 32'h0, rd, er, lt);
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("v%0d_err", v), {31'd0, er},
                {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_lat", v), lt, vecs[v].exp_lat);
            chk($sformatf("v%0d_en", v), en_cnt - e0, vecs[v].exp_en);
            chk($sformatf("v%0d_wr", v), wr_cnt - w0, vecs[v].exp_wr);
            @(negedge clk);
            chk($sformatf("v%0d_hreq", v), {31'd0, cpu_halt_req},
                {31'd0, vecs[v].exp_hreq});
            rf_bad = 1'b0;
        end

        halted_force = 1'b1;
        run_txn(1'b1, 1'b0, 5'd9, 32'h9999_0001, 1'b0, 0, 32'h0,
                rd, er, lt);
        run_txn(1'b0, 1'b0, 5'd9, 32'h0, 1'b0, 5, 32'h9999_0001,
                rd, er, lt);
        chk("stall_rd", rd, 32'h9999_0001);
        chk("stall_lat", lt, 3);

        core_mode = 1'b1;
        run_txn(1'b0, 1'b1, 5'd0, 32'h0, 1'b1, 0, 32'h0, rd, er, lt);
        chk("hold1_rd", rd, 32'h0000_0040);
        chk("hold1_lat", lt, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_idle_hreq", {31'd0, cpu_halt_req}, 32'd1);
        end
        run_txn(1'b0, 1'b0, 5'd9, 32'h0, 1'b0, 0, 32'h0, rd, er, lt);
        chk("hold2_rd", rd, 32'h9999_0001);
        chk("hold2_lat", lt, 3);
        @(negedge clk);
        chk("hold2_release", {31'd0, cpu_halt_req}, 32'd0);
        core_mode = 1'b0;

        halted_force = 1'b0;
        e0 = en_cnt;
        @(negedge clk);
        bus.dbg_req_valid = 1'b1;
        bus.dbg_req_we    = 1'b1;
        bus.dbg_req_pc    = 1'b0;
        bus.dbg_req_addr  = 5'd5;
        bus.dbg_req_wdata = 32'h5555_5555;
        bus.dbg_hold      = 1'b1;
        @(posedge clk);
        #1;
        bus.dbg_req_valid = 1'b0;
        chk("mid_req_ready", {31'd0, bus.dbg_req_ready}, 32'd0);
        chk("mid_halt_req", {31'd0, cpu_halt_req}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b1;
        halted_force = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_req_ready", {31'd0, bus.dbg_req_ready}, 32'd1);
        chk("mrst_rsp_valid", {31'd0, bus.dbg_rsp_valid}, 32'd0);
        chk("mrst_rdata", bus.dbg_rsp_rdata, 32'd0);
        chk("mrst_err", {31'd0, bus.dbg_rsp_err}, 32'd0);
        chk("mrst_halt_req", {31'd0, cpu_halt_req}, 32'd0);
        chk("mrst_rf_en", {31'd0, rf_dbg_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_idle", {31'd0, bus.dbg_rsp_valid}, 32'd0);
        chk("mrst_no_strobe", en_cnt - e0, 0);
        chk("mrst_x5_model", rf[5], 32'h0);
        run_txn(1'b0, 1'b0, 5'd5, 32'h0, 1'b0, 0, 32'h0, rd, er, lt);
        chk("mrst_x5_read", rd, 32'h0);
        chk("mrst_x5_err", {31'd0, er}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=done");
        $fatal(1, "timeout");
    end
endmodule
